// File: rtl/axi4_multichannel_elastic_bridge.sv
// axi4_multichannel_elastic_bridge
//
// Purpose: connects NUM_CHANNELS upstream AXI4 managers to their downstream
// subordinates. Every channel/direction (AR, AW, W, R, B) of every channel
// passes through its own DEPTH-entry elastic FIFO, so no valid/ready path
// crosses the block combinationally. Each channel also tracks its outstanding
// reads and writes, and throttles new requests when a counter saturates.
// A global freeze stalls every handshake while holding all state.
//
// Ports:
//   clock, reset              sole clock; synchronous active-high reset
//   freeze                    forces every valid/ready output to 0
//   up_ar_*, up_aw_*, up_w_*  upstream requests in (packed, channel c at c*W +: W)
//   up_r_*, up_b_*            upstream responses out
//   dn_*                      downstream mirror of up_* with directions reversed
//   idle                      per channel: all five FIFOs empty, both counters 0
//   rd_outstanding,
//   wr_outstanding            live per-channel counters, OUT_BITS each

// One elastic FIFO. The input-side ready comes from a register holding
// "not full after this cycle", so it never depends on the output-side ready.
module axi4_multichannel_elastic_bridge_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             freeze,
    input  logic             block_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             empty
);
    localparam int PTR_BITS = $clog2(DEPTH);
    localparam logic [PTR_BITS:0] FULL_COUNT = (PTR_BITS+1)'(DEPTH);

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [PTR_BITS-1:0] wr_ptr;
    logic [PTR_BITS-1:0] rd_ptr;
    logic [PTR_BITS:0]   count;
    logic [PTR_BITS:0]   count_nxt;
    logic                not_full_q;
    logic                enq;
    logic                deq;

    // Reset is folded in combinationally so nothing handshakes in the reset cycle.
    assign in_ready  = not_full_q & ~freeze & ~reset & ~block_in;
    assign out_valid = (count != '0) & ~freeze & ~reset;
    assign out_data  = mem[rd_ptr];
    assign empty     = (count == '0);
    assign enq       = in_valid & in_ready;
    assign deq       = out_valid & out_ready;

    always_comb begin
        count_nxt = count;
        if (enq && !deq) begin
            count_nxt = count + 1'b1;
        end else if (deq && !enq) begin
            count_nxt = count - 1'b1;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            not_full_q <= 1'b1;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (deq) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count      <= count_nxt;
            not_full_q <= (count_nxt != FULL_COUNT);
        end
    end

    always_ff @(posedge clock) begin
        if (enq) begin
            mem[wr_ptr] <= in_data;
        end
    end
endmodule

module axi4_multichannel_elastic_bridge #(
    parameter int NUM_CHANNELS = 4,
    parameter int ADDR_BITS    = 34,
    parameter int ID_BITS      = 4,
    parameter int DATA_BITS    = 64,
    parameter int STRB_BITS    = DATA_BITS / 8,
    parameter int DEPTH        = 2,
    parameter int OUT_BITS     = 6
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              freeze,
    input  logic [NUM_CHANNELS-1:0]           up_ar_valid,
    output logic [NUM_CHANNELS-1:0]           up_ar_ready,
    input  logic [NUM_CHANNELS*ADDR_BITS-1:0] up_ar_addr,
    input  logic [NUM_CHANNELS*ID_BITS-1:0]   up_ar_id,
    input  logic [NUM_CHANNELS*3-1:0]         up_ar_size,
    input  logic [NUM_CHANNELS*8-1:0]         up_ar_len,
    input  logic [NUM_CHANNELS-1:0]           up_aw_valid,
    output logic [NUM_CHANNELS-1:0]           up_aw_ready,
    input  logic [NUM_CHANNELS*ADDR_BITS-1:0] up_aw_addr,
    input  logic [NUM_CHANNELS*ID_BITS-1:0]   up_aw_id,
    input  logic [NUM_CHANNELS*3-1:0]         up_aw_size,
    input  logic [NUM_CHANNELS*8-1:0]         up_aw_len,
    input  logic [NUM_CHANNELS-1:0]           up_w_valid,
    output logic [NUM_CHANNELS-1:0]           up_w_ready,
    input  logic [NUM_CHANNELS*DATA_BITS-1:0] up_w_data,
    input  logic [NUM_CHANNELS*STRB_BITS-1:0] up_w_strb,
    input  logic [NUM_CHANNELS-1:0]           up_w_last,
    output logic [NUM_CHANNELS-1:0]           up_r_valid,
    input  logic [NUM_CHANNELS-1:0]           up_r_ready,
    output logic [NUM_CHANNELS*DATA_BITS-1:0] up_r_data,
    output logic [NUM_CHANNELS*ID_BITS-1:0]   up_r_id,
    output logic [NUM_CHANNELS*2-1:0]         up_r_resp,
    output logic [NUM_CHANNELS-1:0]           up_r_last,
    output logic [NUM_CHANNELS-1:0]           up_b_valid,
    input  logic [NUM_CHANNELS-1:0]           up_b_ready,
    output logic [NUM_CHANNELS*ID_BITS-1:0]   up_b_id,
    output logic [NUM_CHANNELS*2-1:0]         up_b_resp,
    output logic [NUM_CHANNELS-1:0]           dn_ar_valid,
    input  logic [NUM_CHANNELS-1:0]           dn_ar_ready,
    output logic [NUM_CHANNELS*ADDR_BITS-1:0] dn_ar_addr,
    output logic [NUM_CHANNELS*ID_BITS-1:0]   dn_ar_id,
    output logic [NUM_CHANNELS*3-1:0]         dn_ar_size,
    output logic [NUM_CHANNELS*8-1:0]         dn_ar_len,
    output logic [NUM_CHANNELS-1:0]           dn_aw_valid,
    input  logic [NUM_CHANNELS-1:0]           dn_aw_ready,
    output logic [NUM_CHANNELS*ADDR_BITS-1:0] dn_aw_addr,
    output logic [NUM_CHANNELS*ID_BITS-1:0]   dn_aw_id,
    output logic [NUM_CHANNELS*3-1:0]         dn_aw_size,
    output logic [NUM_CHANNELS*8-1:0]         dn_aw_len,
    output logic [NUM_CHANNELS-1:0]           dn_w_valid,
    input  logic [NUM_CHANNELS-1:0]           dn_w_ready,
    output logic [NUM_CHANNELS*DATA_BITS-1:0] dn_w_data,
    output logic [NUM_CHANNELS*STRB_BITS-1:0] dn_w_strb,
    output logic [NUM_CHANNELS-1:0]           dn_w_last,
    input  logic [NUM_CHANNELS-1:0]           dn_r_valid,
    output logic [NUM_CHANNELS-1:0]           dn_r_ready,
    input  logic [NUM_CHANNELS*DATA_BITS-1:0] dn_r_data,
    input  logic [NUM_CHANNELS*ID_BITS-1:0]   dn_r_id,
    input  logic [NUM_CHANNELS*2-1:0]         dn_r_resp,
    input  logic [NUM_CHANNELS-1:0]           dn_r_last,
    input  logic [NUM_CHANNELS-1:0]           dn_b_valid,
    output logic [NUM_CHANNELS-1:0]           dn_b_ready,
    input  logic [NUM_CHANNELS*ID_BITS-1:0]   dn_b_id,
    input  logic [NUM_CHANNELS*2-1:0]         dn_b_resp,
    output logic [NUM_CHANNELS-1:0]           idle,
    output logic [NUM_CHANNELS*OUT_BITS-1:0]  rd_outstanding,
    output logic [NUM_CHANNELS*OUT_BITS-1:0]  wr_outstanding
);
    localparam int A_W = ADDR_BITS + ID_BITS + 3 + 8;
    localparam int W_W = DATA_BITS + STRB_BITS + 1;
    localparam int R_W = DATA_BITS + ID_BITS + 2 + 1;
    localparam int B_W = ID_BITS + 2;

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
        logic [A_W-1:0]      ar_in, ar_out, aw_in, aw_out;
        logic [W_W-1:0]      w_in, w_out;
        logic [R_W-1:0]      r_in, r_out;
        logic [B_W-1:0]      b_in, b_out;
        logic [4:0]          fifo_empty;
        logic [OUT_BITS-1:0] rd_cnt, wr_cnt;
        logic                rd_inc, rd_dec, wr_inc, wr_dec;
        logic                rd_sat, wr_sat;

        assign ar_in = {up_ar_addr[c*ADDR_BITS +: ADDR_BITS], up_ar_id[c*ID_BITS +: ID_BITS],
                        up_ar_size[c*3 +: 3], up_ar_len[c*8 +: 8]};
        assign {dn_ar_addr[c*ADDR_BITS +: ADDR_BITS], dn_ar_id[c*ID_BITS +: ID_BITS],
                dn_ar_size[c*3 +: 3], dn_ar_len[c*8 +: 8]} = ar_out;
        assign aw_in = {up_aw_addr[c*ADDR_BITS +: ADDR_BITS], up_aw_id[c*ID_BITS +: ID_BITS],
                        up_aw_size[c*3 +: 3], up_aw_len[c*8 +: 8]};
        assign {dn_aw_addr[c*ADDR_BITS +: ADDR_BITS], dn_aw_id[c*ID_BITS +: ID_BITS],
                dn_aw_size[c*3 +: 3], dn_aw_len[c*8 +: 8]} = aw_out;
        assign w_in = {up_w_data[c*DATA_BITS +: DATA_BITS], up_w_strb[c*STRB_BITS +: STRB_BITS],
                       up_w_last[c]};
        assign {dn_w_data[c*DATA_BITS +: DATA_BITS], dn_w_strb[c*STRB_BITS +: STRB_BITS],
                dn_w_last[c]} = w_out;
        assign r_in = {dn_r_data[c*DATA_BITS +: DATA_BITS], dn_r_id[c*ID_BITS +: ID_BITS],
                       dn_r_resp[c*2 +: 2], dn_r_last[c]};
        assign {up_r_data[c*DATA_BITS +: DATA_BITS], up_r_id[c*ID_BITS +: ID_BITS],
                up_r_resp[c*2 +: 2], up_r_last[c]} = r_out;
        assign b_in = {dn_b_id[c*ID_BITS +: ID_BITS], dn_b_resp[c*2 +: 2]};
        assign {up_b_id[c*ID_BITS +: ID_BITS], up_b_resp[c*2 +: 2]} = b_out;

        // A saturated counter blocks new requests instead of wrapping.
        assign rd_sat = (rd_cnt == '1);
        assign wr_sat = (wr_cnt == '1);

        axi4_multichannel_elastic_bridge_fifo #(.WIDTH(A_W), .DEPTH(DEPTH)) u_ar (
            .clock(clock), .reset(reset), .freeze(freeze), .block_in(rd_sat),
            .in_valid(up_ar_valid[c]), .in_ready(up_ar_ready[c]), .in_data(ar_in),
            .out_valid(dn_ar_valid[c]), .out_ready(dn_ar_ready[c]), .out_data(ar_out),
            .empty(fifo_empty[0]));
        axi4_multichannel_elastic_bridge_fifo #(.WIDTH(A_W), .DEPTH(DEPTH)) u_aw (
            .clock(clock), .reset(reset), .freeze(freeze), .block_in(wr_sat),
            .in_valid(up_aw_valid[c]), .in_ready(up_aw_ready[c]), .in_data(aw_in),
            .out_valid(dn_aw_valid[c]), .out_ready(dn_aw_ready[c]), .out_data(aw_out),
            .empty(fifo_empty[1]));
        axi4_multichannel_elastic_bridge_fifo #(.WIDTH(W_W), .DEPTH(DEPTH)) u_w (
            .clock(clock), .reset(reset), .freeze(freeze), .block_in(1'b0),
            .in_valid(up_w_valid[c]), .in_ready(up_w_ready[c]), .in_data(w_in),
            .out_valid(dn_w_valid[c]), .out_ready(dn_w_ready[c]), .out_data(w_out),
            .empty(fifo_empty[2]));
        axi4_multichannel_elastic_bridge_fifo #(.WIDTH(R_W), .DEPTH(DEPTH)) u_r (
            .clock(clock), .reset(reset), .freeze(freeze), .block_in(1'b0),
            .in_valid(dn_r_valid[c]), .in_ready(dn_r_ready[c]), .in_data(r_in),
            .out_valid(up_r_valid[c]), .out_ready(up_r_ready[c]), .out_data(r_out),
            .empty(fifo_empty[3]));
        axi4_multichannel_elastic_bridge_fifo #(.WIDTH(B_W), .DEPTH(DEPTH)) u_b (
            .clock(clock), .reset(reset), .freeze(freeze), .block_in(1'b0),
            .in_valid(dn_b_valid[c]), .in_ready(dn_b_ready[c]), .in_data(b_in),
            .out_valid(up_b_valid[c]), .out_ready(up_b_ready[c]), .out_data(b_out),
            .empty(fifo_empty[4]));

        // Reads retire only on the last R beat; writes retire on the B beat.
        assign rd_inc = up_ar_valid[c] & up_ar_ready[c];
        assign rd_dec = up_r_valid[c] & up_r_ready[c] & up_r_last[c];
        assign wr_inc = up_aw_valid[c] & up_aw_ready[c];
        assign wr_dec = up_b_valid[c] & up_b_ready[c];

        // A response with nothing outstanding is a protocol error; the counter clamps at 0.
        always_ff @(posedge clock) begin
            if (reset) begin
                rd_cnt <= '0;
                wr_cnt <= '0;
            end else begin
                if (rd_inc && !rd_dec) begin
                    rd_cnt <= rd_cnt + 1'b1;
                end else if (rd_dec && !rd_inc && rd_cnt != '0) begin
                    rd_cnt <= rd_cnt - 1'b1;
                end
                if (wr_inc && !wr_dec) begin
                    wr_cnt <= wr_cnt + 1'b1;
                end else if (wr_dec && !wr_inc && wr_cnt != '0) begin
                    wr_cnt <= wr_cnt - 1'b1;
                end
            end
        end

`ifndef SYNTHESIS
        always_ff @(posedge clock) begin
            if (!reset) begin
                assert (!(rd_dec && !rd_inc && rd_cnt == '0))
                    else $error("read response underflow on channel %0d", c);
                assert (!(wr_dec && !wr_inc && wr_cnt == '0))
                    else $error("write response underflow on channel %0d", c);
            end
        end
`endif

        assign rd_outstanding[c*OUT_BITS +: OUT_BITS] = rd_cnt;
        assign wr_outstanding[c*OUT_BITS +: OUT_BITS] = wr_cnt;
        assign idle[c] = (&fifo_empty) & (rd_cnt == '0) & (wr_cnt == '0);
    end
endmodule

// File: tb/tb_axi4_multichannel_elastic_bridge.sv
// tb_axi4_multichannel_elastic_bridge
//
// Purpose: directed self-checking bench for axi4_multichannel_elastic_bridge
// with NUM_CHANNELS=4, DEPTH=2, OUT_BITS=2. Covers reset state, a single read,
// W backpressure, AW throttling, freeze mid-burst, channel independence and
// reset with beats buffered. Inputs change 1 time unit after the rising edge
// and outputs are checked 1 unit later, well away from the next edge.
module tb_axi4_multichannel_elastic_bridge;
    localparam int NC = 4;
    localparam int AB = 34;
    localparam int IB = 4;
    localparam int DB = 64;
    localparam int SB = 8;
    localparam int OB = 2;

    logic            clock;
    logic            reset;
    logic            freeze;
    logic [NC-1:0]   up_ar_valid, up_ar_ready, up_aw_valid, up_aw_ready;
    logic [NC*AB-1:0] up_ar_addr, up_aw_addr, dn_ar_addr, dn_aw_addr;
    logic [NC*IB-1:0] up_ar_id, up_aw_id, dn_ar_id, dn_aw_id;
    logic [NC*3-1:0] up_ar_size, up_aw_size, dn_ar_size, dn_aw_size;
    logic [NC*8-1:0] up_ar_len, up_aw_len, dn_ar_len, dn_aw_len;
    logic [NC-1:0]   up_w_valid, up_w_ready, up_w_last;
    logic [NC*DB-1:0] up_w_data, dn_w_data, up_r_data, dn_r_data;
    logic [NC*SB-1:0] up_w_strb, dn_w_strb;
    logic [NC-1:0]   up_r_valid, up_r_ready, up_r_last, up_b_valid, up_b_ready;
    logic [NC*IB-1:0] up_r_id, up_b_id, dn_r_id, dn_b_id;
    logic [NC*2-1:0] up_r_resp, up_b_resp, dn_r_resp, dn_b_resp;
    logic [NC-1:0]   dn_ar_valid, dn_ar_ready, dn_aw_valid, dn_aw_ready;
    logic [NC-1:0]   dn_w_valid, dn_w_ready, dn_w_last;
    logic [NC-1:0]   dn_r_valid, dn_r_ready, dn_r_last, dn_b_valid, dn_b_ready;
    logic [NC-1:0]   idle;
    logic [NC*OB-1:0] rd_outstanding, wr_outstanding;

    int total = 0;
    int bad = 0;

    logic [64:0] wq[$];
    int          r_hs [NC];
    logic        count_en = 1'b0;

    axi4_multichannel_elastic_bridge #(
        .NUM_CHANNELS(NC), .ADDR_BITS(AB), .ID_BITS(IB), .DATA_BITS(DB),
        .STRB_BITS(SB), .DEPTH(2), .OUT_BITS(OB)
    ) dut (
        .clock(clock), .reset(reset), .freeze(freeze),
        .up_ar_valid(up_ar_valid), .up_ar_ready(up_ar_ready), .up_ar_addr(up_ar_addr),
        .up_ar_id(up_ar_id), .up_ar_size(up_ar_size), .up_ar_len(up_ar_len),
        .up_aw_valid(up_aw_valid), .up_aw_ready(up_aw_ready), .up_aw_addr(up_aw_addr),
        .up_aw_id(up_aw_id), .up_aw_size(up_aw_size), .up_aw_len(up_aw_len),
        .up_w_valid(up_w_valid), .up_w_ready(up_w_ready), .up_w_data(up_w_data),
        .up_w_strb(up_w_strb), .up_w_last(up_w_last),
        .up_r_valid(up_r_valid), .up_r_ready(up_r_ready), .up_r_data(up_r_data),
        .up_r_id(up_r_id), .up_r_resp(up_r_resp), .up_r_last(up_r_last),
        .up_b_valid(up_b_valid), .up_b_ready(up_b_ready), .up_b_id(up_b_id),
        .up_b_resp(up_b_resp),
        .dn_ar_valid(dn_ar_valid), .dn_ar_ready(dn_ar_ready), .dn_ar_addr(dn_ar_addr),
        .dn_ar_id(dn_ar_id), .dn_ar_size(dn_ar_size), .dn_ar_len(dn_ar_len),
        .dn_aw_valid(dn_aw_valid), .dn_aw_ready(dn_aw_ready), .dn_aw_addr(dn_aw_addr),
        .dn_aw_id(dn_aw_id), .dn_aw_size(dn_aw_size), .dn_aw_len(dn_aw_len),
        .dn_w_valid(dn_w_valid), .dn_w_ready(dn_w_ready), .dn_w_data(dn_w_data),
        .dn_w_strb(dn_w_strb), .dn_w_last(dn_w_last),
        .dn_r_valid(dn_r_valid), .dn_r_ready(dn_r_ready), .dn_r_data(dn_r_data),
        .dn_r_id(dn_r_id), .dn_r_resp(dn_r_resp), .dn_r_last(dn_r_last),
        .dn_b_valid(dn_b_valid), .dn_b_ready(dn_b_ready), .dn_b_id(dn_b_id),
        .dn_b_resp(dn_b_resp),
        .idle(idle), .rd_outstanding(rd_outstanding), .wr_outstanding(wr_outstanding)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Handshakes are recorded at the falling edge, where inputs are stable
    // and the following rising edge will complete them.
    always @(negedge clock) begin
        if (dn_w_valid[3] && dn_w_ready[3]) begin
            wq.push_back({dn_w_last[3], dn_w_data[3*DB +: DB]});
        end
        if (count_en) begin
            for (int c = 0; c < NC; c++) begin
                if (up_r_valid[c] && up_r_ready[c]) begin
                    r_hs[c] = r_hs[c] + 1;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] want);
        total = total + 1;
        if (got !== want) begin
            bad = bad + 1;
            $display("[TB] FAIL %s: got=0x%0h want=0x%0h", tag, got, want);
        end
    endtask

    // Advance one cycle; the caller changes inputs right after this returns.
    task automatic applyStimulus();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        reset = 1'b1; freeze = 1'b0;
        up_ar_valid = '0; up_ar_addr = '0; up_ar_id = '0; up_ar_size = '0; up_ar_len = '0;
        up_aw_valid = '0; up_aw_addr = '0; up_aw_id = '0; up_aw_size = '0; up_aw_len = '0;
        up_w_valid = '0; up_w_data = '0; up_w_strb = '0; up_w_last = '0;
        up_r_ready = '0; up_b_ready = '0;
        dn_ar_ready = '0; dn_aw_ready = '0; dn_w_ready = '0;
        dn_r_valid = '0; dn_r_data = '0; dn_r_id = '0; dn_r_resp = '0; dn_r_last = '0;
        dn_b_valid = '0; dn_b_id = '0; dn_b_resp = '0;
        for (int c = 0; c < NC; c++) r_hs[c] = 0;

        // Reset state
        applyStimulus();
        applyStimulus();
        settle();
        checkOutput("rst_up_ar_ready", up_ar_ready, 4'h0);
        checkOutput("rst_dn_r_ready", dn_r_ready, 4'h0);
        reset = 1'b0;
        applyStimulus();
        settle();
        checkOutput("post_rst_up_aw_ready", up_aw_ready, 4'hF);
        checkOutput("post_rst_idle", idle, 4'hF);
        checkOutput("post_rst_rd_out", rd_outstanding, 8'h00);
        checkOutput("post_rst_dn_ar_valid", dn_ar_valid, 4'h0);

        // Single read on channel 0
        up_ar_valid[0] = 1'b1; up_ar_addr[0 +: AB] = 34'h1000; up_ar_id[0 +: IB] = 4'd3;
        up_ar_size[0 +: 3] = 3'd3; up_ar_len[0 +: 8] = 8'd0;
        settle();
        checkOutput("rd_up_ar_ready", up_ar_ready[0], 1'b1);
        checkOutput("rd_dn_ar_valid_early", dn_ar_valid, 4'h0);
        applyStimulus();
        up_ar_valid = '0;
        settle();
        checkOutput("rd_dn_ar_valid", dn_ar_valid, 4'h1);
        checkOutput("rd_dn_ar_addr", dn_ar_addr[0 +: AB], 34'h1000);
        checkOutput("rd_dn_ar_id", dn_ar_id[0 +: IB], 4'd3);
        checkOutput("rd_dn_ar_len", dn_ar_len[0 +: 8], 8'd0);
        checkOutput("rd_out_1", rd_outstanding[0 +: OB], 2'd1);
        checkOutput("rd_idle0_busy", idle[0], 1'b0);
        dn_ar_ready[0] = 1'b1;
        applyStimulus();
        dn_ar_ready[0] = 1'b0;
        dn_r_valid[0] = 1'b1; dn_r_data[0 +: DB] = 64'hDEADBEEF; dn_r_id[0 +: IB] = 4'd3;
        dn_r_last[0] = 1'b1;
        settle();
        checkOutput("rd_dn_r_ready", dn_r_ready[0], 1'b1);
        applyStimulus();
        dn_r_valid = '0; dn_r_last = '0;
        settle();
        checkOutput("rd_up_r_valid", up_r_valid, 4'h1);
        checkOutput("rd_up_r_data", up_r_data[0 +: DB], 64'hDEADBEEF);
        checkOutput("rd_up_r_id", up_r_id[0 +: IB], 4'd3);
        checkOutput("rd_up_r_last", up_r_last[0], 1'b1);
        up_r_ready[0] = 1'b1;
        applyStimulus();
        up_r_ready = '0;
        settle();
        checkOutput("rd_out_0", rd_outstanding[0 +: OB], 2'd0);
        checkOutput("rd_idle0_back", idle[0], 1'b1);

        // W backpressure on channel 1
        up_w_valid[1] = 1'b1; up_w_strb[1*SB +: SB] = 8'hFF;
        up_w_data[1*DB +: DB] = 64'hA1;
        settle();
        checkOutput("bp_ready_beat1", up_w_ready[1], 1'b1);
        applyStimulus();
        up_w_data[1*DB +: DB] = 64'hA2;
        settle();
        checkOutput("bp_ready_beat2", up_w_ready[1], 1'b1);
        applyStimulus();
        up_w_data[1*DB +: DB] = 64'hA3;
        settle();
        checkOutput("bp_ready_full", up_w_ready[1], 1'b0);
        applyStimulus();
        dn_w_ready[1] = 1'b1;
        settle();
        checkOutput("bp_out_A1", {dn_w_valid[1], dn_w_data[1*DB +: DB]}, {1'b1, 64'hA1});
        checkOutput("bp_ready_still_full", up_w_ready[1], 1'b0);
        applyStimulus();
        settle();
        checkOutput("bp_out_A2", {dn_w_valid[1], dn_w_data[1*DB +: DB]}, {1'b1, 64'hA2});
        checkOutput("bp_ready_reopen", up_w_ready[1], 1'b1);
        applyStimulus();
        up_w_valid[1] = 1'b0;
        settle();
        checkOutput("bp_out_A3", {dn_w_valid[1], dn_w_data[1*DB +: DB]}, {1'b1, 64'hA3});
        applyStimulus();
        settle();
        checkOutput("bp_no_dup", dn_w_valid[1], 1'b0);
        dn_w_ready[1] = 1'b0;

        // AW throttle on channel 2 (OUT_BITS=2 saturates at 3)
        dn_aw_ready[2] = 1'b1;
        up_aw_valid[2] = 1'b1; up_aw_addr[2*AB +: AB] = 34'h2000; up_aw_id[2*IB +: IB] = 4'd5;
        for (int i = 0; i < 3; i++) begin
            settle();
            checkOutput($sformatf("thr_ready_%0d", i), up_aw_ready[2], 1'b1);
            applyStimulus();
        end
        settle();
        checkOutput("thr_wr_out_3", wr_outstanding[2*OB +: OB], 2'd3);
        checkOutput("thr_ready_blocked", up_aw_ready[2], 1'b0);
        applyStimulus();
        up_aw_valid[2] = 1'b0;
        settle();
        checkOutput("thr_wr_out_hold", wr_outstanding[2*OB +: OB], 2'd3);
        dn_b_valid[2] = 1'b1; dn_b_id[2*IB +: IB] = 4'd5;
        applyStimulus();
        dn_b_valid = '0;
        settle();
        checkOutput("thr_up_b_valid", up_b_valid[2], 1'b1);
        checkOutput("thr_up_b_id", up_b_id[2*IB +: IB], 4'd5);
        up_b_ready[2] = 1'b1;
        settle();
        checkOutput("thr_ready_same_cycle", up_aw_ready[2], 1'b0);
        applyStimulus();
        up_b_ready = '0;
        settle();
        checkOutput("thr_wr_out_2", wr_outstanding[2*OB +: OB], 2'd2);
        checkOutput("thr_ready_back", up_aw_ready[2], 1'b1);
        dn_aw_ready = '0;

        // Freeze in the middle of a 4-beat write burst on channel 3
        dn_w_ready[3] = 1'b1;
        wq.delete();
        for (int k = 0; k < 4; k++) begin
            int n;
            up_w_valid[3] = 1'b1; up_w_strb[3*SB +: SB] = 8'hFF;
            up_w_data[3*DB +: DB] = 64'hB1 + 64'(k); up_w_last[3] = (k == 3);
            if (k == 2) begin
                freeze = 1'b1;
                for (int f = 0; f < 5; f++) begin
                    settle();
                    checkOutput($sformatf("frz_up_w_ready_%0d", f), up_w_ready, 4'h0);
                    checkOutput($sformatf("frz_dn_w_valid_%0d", f), dn_w_valid, 4'h0);
                    checkOutput($sformatf("frz_misc_%0d", f),
                                {up_ar_ready, dn_r_ready, up_b_valid}, 12'h000);
                    checkOutput($sformatf("frz_idle3_%0d", f), idle[3], 1'b0);
                    applyStimulus();
                end
                freeze = 1'b0;
            end
            settle();
            n = 0;
            while (!up_w_ready[3] && n < 20) begin
                applyStimulus();
                settle();
                n++;
            end
            if (n >= 20) checkOutput("frz_ready_timeout", 1'b0, 1'b1);
            applyStimulus();
        end
        up_w_valid[3] = 1'b0; up_w_last[3] = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus();
        checkOutput("frz_beats", wq.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < wq.size()) begin
                checkOutput($sformatf("frz_beat_%0d", k), wq[k], {(k == 3), 64'hB1 + 64'(k)});
            end
        end
        dn_w_ready = '0;

        // Channel independence: stream R on 0/1/3 while channel 2 is stalled
        up_ar_valid = 4'hF; dn_ar_ready = 4'hF;
        for (int c = 0; c < NC; c++) up_ar_len[c*8 +: 8] = 8'd7;
        settle();
        checkOutput("ind_ar_ready", up_ar_ready, 4'hF);
        applyStimulus();
        up_ar_valid = '0;
        settle();
        checkOutput("ind_rd_out", rd_outstanding, 8'b01_01_01_01);
        up_r_ready = 4'b1011;
        dn_r_valid = 4'hF; dn_r_last = '0;
        for (int c = 0; c < NC; c++) dn_r_data[c*DB +: DB] = 64'h100 * 64'(c);
        applyStimulus();
        applyStimulus();
        count_en = 1'b1;
        for (int i = 0; i < 8; i++) applyStimulus();
        count_en = 1'b0;
        settle();
        checkOutput("ind_ch0_beats", r_hs[0], 8);
        checkOutput("ind_ch1_beats", r_hs[1], 8);
        checkOutput("ind_ch3_beats", r_hs[3], 8);
        checkOutput("ind_ch2_beats", r_hs[2], 0);
        checkOutput("ind_ch2_dn_ready", dn_r_ready[2], 1'b0);
        checkOutput("ind_ch2_idle", idle[2], 1'b0);
        dn_r_valid = '0; dn_ar_ready = '0;
        for (int i = 0; i < 3; i++) applyStimulus();
        settle();
        checkOutput("ind_ch2_buffered", up_r_valid, 4'b0100);

        // Reset with two beats buffered in channel 2's R FIFO
        reset = 1'b1;
        settle();
        checkOutput("mrst_valid_in_reset", up_r_valid, 4'h0);
        checkOutput("mrst_ready_in_reset", up_ar_ready, 4'h0);
        applyStimulus();
        reset = 1'b0;
        up_r_ready = 4'hF;
        settle();
        checkOutput("mrst_up_r_valid", up_r_valid, 4'h0);
        checkOutput("mrst_rd_out", rd_outstanding, 8'h00);
        checkOutput("mrst_wr_out", wr_outstanding, 8'h00);
        checkOutput("mrst_idle", idle, 4'hF);
        for (int c = 0; c < NC; c++) r_hs[c] = 0;
        count_en = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus();
        count_en = 1'b0;
        checkOutput("mrst_no_stale", r_hs[0] + r_hs[1] + r_hs[2] + r_hs[3], 0);
        checkOutput("mrst_aw_ready", up_aw_ready, 4'hF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/axi4_multichannel_elastic_bridge.md
Name: axi4_multichannel_elastic_bridge

Overview:
- Parametrised AXI4 (AR/AW/W/R/B) bridge between NUM_CHANNELS upstream managers (FPGATop host/mem ports) and downstream subordinates (simulator tick models or memory).
- Each channel/direction gets a DEPTH-entry elastic buffer, so there is no combinational valid/ready path across the block.
- Generalises the fixed one-cycle sync registering into configurable depth and channel count, with per-channel outstanding-transaction tracking.
- A global freeze mode lets the harness stall and drain traffic safely.

Parameters:
- NUM_CHANNELS, 4: number of independent AXI4 channels.
- ADDR_BITS, 34: AR/AW address width.
- ID_BITS, 4: AXI ID width.
- DATA_BITS, 64: R/W data width; multiple of 8.
- STRB_BITS, DATA_BITS/8: write strobe width.
- DEPTH, 2: entries per per-channel buffer; power of 2, at least 2.
- OUT_BITS, 6: width of the outstanding-transaction counters.

Ports:
- clock  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- freeze  in  1  stall all handshakes on both sides.
- up_ar_valid/ready, up_aw_valid/ready, up_w_valid/ready  in/out  NUM_CHANNELS  upstream request handshakes, one bit per channel.
- up_ar_addr, up_aw_addr  in  NUM_CHANNELS*ADDR_BITS  packed; channel c occupies bits [c*ADDR_BITS +: ADDR_BITS].
- up_ar_id, up_aw_id  in  NUM_CHANNELS*ID_BITS.
- up_ar_size, up_aw_size  in  NUM_CHANNELS*3.
- up_ar_len, up_aw_len  in  NUM_CHANNELS*8.
- up_w_data  in  NUM_CHANNELS*DATA_BITS.
- up_w_strb  in  NUM_CHANNELS*STRB_BITS.
- up_w_last  in  NUM_CHANNELS.
- up_r_valid/ready, up_b_valid/ready  out/in  NUM_CHANNELS  upstream response handshakes.
- up_r_data  out  NUM_CHANNELS*DATA_BITS.
- up_r_id, up_b_id  out  NUM_CHANNELS*ID_BITS.
- up_r_resp, up_b_resp  out  NUM_CHANNELS*2.
- up_r_last  out  NUM_CHANNELS.
- dn_*: mirror of every up_* signal above with directions reversed; identical widths and packing.
- idle  out  NUM_CHANNELS  channel c has all five buffers empty and both outstanding counters at 0.
- rd_outstanding, wr_outstanding  out  NUM_CHANNELS*OUT_BITS  live counter values.

Behaviour:
- Per channel c there are five independent FIFOs of DEPTH entries:
  - AR, AW, W carry up to dn.
  - R, B carry dn to up.
  - Each FIFO stores the full payload: all fields except valid/ready.
- FIFO output side: valid = count != 0, unless frozen.
- FIFO input side: ready = registered (count != DEPTH), unless frozen or throttled.
  - Ready never depends on same-cycle output ready; a full FIFO refuses a beat even if it dequeues in the same cycle.
- Latency: a beat accepted on cycle N is presented on cycle N+1 at the earliest.
  - Ordering within a FIFO is strict FIFO; there is no ordering across channels or across AR/AW/W.
- Enqueue and dequeue in the same cycle (FIFO not full): count unchanged, data correct.
- Pointers are DEPTH-wrapped: log2(DEPTH) bits plus a separate count of log2(DEPTH)+1 bits.
- freeze=1:
  - All up_*_ready, dn_*_ready, up_*_valid and dn_*_valid outputs are 0 combinationally.
  - FIFO contents, pointers and counters hold.
  - Deasserting freeze resumes with no loss or duplication.
- rd_outstanding[c]:
  - +1 on an up_ar handshake.
  - -1 on an up_r handshake with up_r_last=1.
  - Both in the same cycle: unchanged.
- wr_outstanding[c]:
  - +1 on an up_aw handshake.
  - -1 on an up_b handshake.
  - Both in the same cycle: unchanged.
- Throttle: when a counter equals 2^OUT_BITS-1, the corresponding up_ar_ready / up_aw_ready is 0. Counters never wrap.
- Underflow (a response arrives with the counter at 0) is a protocol error:
  - Counter stays 0.
  - Simulation-only assertion fires (guarded by ifndef SYNTHESIS).
- Reset, synchronous, also when asserted mid-burst:
  - All FIFOs empty, counters 0.
  - All valid outputs 0 and all ready outputs 0 during the reset cycle; ready rises the cycle after reset deasserts.
  - Beats in flight are discarded.
  - idle=all-ones from the cycle after reset.
- Channels are fully independent: a stall on channel c never affects channel d.

Test Plan:
- Single read, ch0: AR(addr=0x1000, id=3, len=0) -> dn_ar_valid on cycle N+1 with identical fields; dn R(data=0xDEADBEEF, last=1) -> up_r on the following cycle; rd_outstanding[0] goes 0→1→0; idle[0] returns to 1.
- Full/backpressure, DEPTH=2: hold dn_w_ready=0 and drive 3 W beats -> up_w_ready drops after 2 accepted; release -> beats exit in order, each exactly once.
- Throttle, OUT_BITS=2: issue 3 AW with no B -> up_aw_ready=0 while wr_outstanding=3; one B handshake -> ready returns next cycle, counter=2.
- Freeze: assert freeze mid 4-beat write burst for 5 cycles -> all valid/ready 0, counts held; deassert -> remaining beats delivered, w_last on beat 4.
- Channel independence, NUM_CHANNELS=4: stall ch2 R while streaming reads on ch0/1/3 -> ch0/1/3 throughput 1 beat/cycle, ch2 idle=0.
- Reset mid-burst: reset with 2 beats buffered -> next cycle all valids 0, counters 0, idle=4'b1111; no stale beats emitted afterwards.
